sub_bytes_seq: RTL
==================

# sub_bytes_seq

Sequential, parametrised AES SubBytes engine. It applies the forward AES S-box to an NBYTES-wide state, one group of LANES bytes per cycle, by time-multiplexing LANES instances of the team's combinational `sbox` cell. It sits between the round-key XOR and ShiftRows in the round datapath. Valid/ready handshakes on both sides let the round controller stall it, and let designers trade area (LANES) against latency (NBYTES/LANES cycles).

## Interface
Parameters:
- NBYTES, 16: bytes per block. Must be a multiple of LANES.
- LANES, 4: S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16, with LANES ≤ NBYTES.
- BEATS (derived, not overridable): NBYTES/LANES.

Ports:
- clk, in, 1: single clock. All state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- in_valid, in, 1: in_data holds a block to substitute.
- in_ready, out, 1: engine accepts a block this cycle.
- in_data, in, 8*NBYTES: input block. Byte i is in_data[8i+7:8i].
- out_valid, out, 1: out_data holds a finished block.
- out_ready, in, 1: consumer takes out_data this cycle.
- out_data, out, 8*NBYTES: substituted block, same byte ordering as in_data.
- busy, out, 1: high when the state is not IDLE.

## Operation
- State machine states: IDLE, RUN, DONE. A beat counter `cnt` is ceil(log2(BEATS)) bits wide, with a minimum of 1 bit. A work register `work` is 8*NBYTES bits wide.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- IDLE:
  - in_ready=1.
  - On an input transfer: work←in_data, cnt←0, go to RUN.
- RUN:
  - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of work are replaced in place by sbox(byte); all other bytes are held.
  - If cnt==BEATS-1, go to DONE and set cnt←0. Otherwise cnt←cnt+1.
  - in_ready=0. in_data is ignored.
- DONE:
  - out_valid=1 and out_data=work, held stable until the output transfer.
  - in_ready=out_ready.
  - On an output transfer with in_valid=1: load the new block into work, cnt←0, go to RUN. There is no idle bubble.
  - On an output transfer with in_valid=0: go to IDLE.
  - With out_ready=0: stay in DONE. work, out_data and out_valid must not change.
- BEATS==1 (LANES==NBYTES): RUN lasts exactly one cycle and substitutes all bytes.
- The S-box is the standard FIPS-197 forward table, e.g. 00→63, 01→7c, 53→ed, ff→16. It comes from `sbox` instances only, with no duplicated table.
- out_valid and out_data are driven by registers (state decode and work). No combinational path from in_data to out_data.

## Timing
- Reset values, forced asynchronously while rst_n=0:
  - state=IDLE, cnt=0, work=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=1.
- Reset mid-block (RUN or DONE): the block is discarded and no out_valid pulse appears. After rst_n deasserts, the engine accepts on the first clk edge if in_valid=1.
- Latency: input transfer at edge k gives out_valid=1 after edge k+BEATS.
- Throughput with out_ready held at 1: one block every BEATS+1 cycles.
- in_ready depends combinationally on out_ready only in DONE. It never depends on in_valid.
- busy=1 from the edge after acceptance until the edge after the final output transfer, when no new block follows.

## Test plan
- FIPS-197 vector, NBYTES=16, LANES=4:
  - Stimulus: in_data bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, out_ready=1.
  - Required: out_valid exactly 4 cycles after acceptance, with out_data bytes = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- Lane sweep: repeat the same vector with LANES=1, 2, 8, 16.
  - Required: identical out_data, with latency of 16, 8, 2 and 1 cycles respectively.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with a different block.
  - Required: out_data stable, out_valid=1, in_ready=0 throughout. The second block is accepted on the same edge that out_ready=1 completes the first transfer.
- Back-to-back streaming:
  - Stimulus: 8 random blocks, in_valid and out_ready always 1, LANES=4.
  - Required: one output every 5 cycles, each matching a software model.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 at cnt=2, then release.
  - Required: out_valid=0, out_data=0, in_ready=1 immediately. No stale output afterwards, and the next block is processed correctly.
- Exhaustive table check:
  - Stimulus: 16 blocks covering bytes 00..ff, with LANES=16 and with LANES=1.
  - Required: every byte matches the FIPS-197 S-box, e.g. 00→63, 53→ed, ff→16.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes engine: substitutes LANES bytes of an NBYTES block per
// cycle through a shared bank of sbox cells, with valid/ready on both sides.

module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

// Handshake: a transfer happens on a rising edge where valid && ready; valid
// never waits on ready, and in_ready never looks at in_valid.
module sub_bytes_seq #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int BEATS = NBYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [8*NBYTES-1:0] r_work;

  logic [7:0]          w_lane_in  [LANES];
  logic [7:0]          w_lane_out [LANES];
  logic [8*NBYTES-1:0] w_work_sub;
  logic                w_in_xfer;
  logic                w_out_xfer;

  // Route the bytes of the current beat to the lanes and back into place
  always_comb begin
    for (int l = 0; l < LANES; l++) w_lane_in[l] = 8'h00;
    w_work_sub = r_work;
    for (int b = 0; b < NBYTES; b++) begin
      if (CW'(b / LANES) == r_cnt) begin
        w_lane_in[b % LANES] = r_work[b*8 +: 8];
        w_work_sub[b*8 +: 8] = w_lane_out[b % LANES];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox u_sbox (
      .i_byte (w_lane_in[l]),
      .o_byte (w_lane_out[l])
    );
  end

  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid  = (r_state == S_DONE);
  assign out_data   = r_work;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_xfer) begin
            r_work  <= in_data;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_work_sub;
          if (r_cnt == CW'(BEATS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // A waiting block is taken on the same edge the result leaves
          if (w_out_xfer) begin
            if (w_in_xfer) begin
              r_work  <= in_data;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
